// File: rtl/uart_prog_loader.sv
// Boot-stage program loader: receives a word-count header and program words over UART 8N1,
// writes them into instruction memory and holds the CPU in reset until the load completes.
module uart_prog_loader #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned MAX_WORDS = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic [9:0]        word_count
);
    localparam int unsigned CPB   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned CNT_W = $clog2(CPB + 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] L_IDLE   = 3'd0;
    localparam logic [2:0] L_HDR_HI = 3'd1;
    localparam logic [2:0] L_HDR_LO = 3'd2;
    localparam logic [2:0] L_DATA   = 3'd3;
    localparam logic [2:0] L_DONE   = 3'd4;
    localparam logic [2:0] L_ERROR  = 3'd5;

    // ---------------- UART receiver ----------------
    logic [1:0]       sync_q;
    logic             rx_prev_q;
    logic [1:0]       rs_q, rs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ferr_q, rx_ferr_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            rs_q       <= R_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            rx_prev_q  <= rx_s;
            rs_q       <= rs_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    // Mid-bit sampling: half a bit after the falling edge, then one bit period per sample
    always_comb begin
        rs_d       = rs_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_byte_d  = rx_byte_q;
        case (rs_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rs_d  = R_START;
                    cnt_d = '0;
                end
            end
            R_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    rs_d  = rx_s ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            R_DATA: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) rs_d = R_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d = '0;
                    rs_d  = R_IDLE;
                    if (rx_s) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = sh_q;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // ---------------- Load FSM ----------------
    logic [2:0]        st_q, st_d;
    logic [7:0]        hdr_hi_q, hdr_hi_d;
    logic [15:0]       n_q, n_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [9:0]        wc_q, wc_d;
    logic              ferr_q, ferr_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       hdr_n;

    assign hdr_n = {hdr_hi_q, rx_byte_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= L_IDLE;
            hdr_hi_q  <= '0;
            n_q       <= '0;
            bidx_q    <= '0;
            word_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wc_q      <= '0;
            ferr_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            hdr_hi_q  <= hdr_hi_d;
            n_q       <= n_d;
            bidx_q    <= bidx_d;
            word_q    <= word_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wc_q      <= wc_d;
            ferr_q    <= ferr_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        hdr_hi_d = hdr_hi_q;
        n_d      = n_q;
        bidx_d   = bidx_q;
        word_d   = word_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wc_d     = wc_q;
        ferr_d   = ferr_q;
        case (st_q)
            L_HDR_HI: begin
                if (rx_ferr_q) begin
                    st_d   = L_ERROR;
                    ferr_d = 1'b1;
                end else if (rx_valid_q) begin
                    hdr_hi_d = rx_byte_q;
                    st_d     = L_HDR_LO;
                end
            end
            L_HDR_LO: begin
                if (rx_ferr_q) begin
                    st_d   = L_ERROR;
                    ferr_d = 1'b1;
                end else if (rx_valid_q) begin
                    n_d = hdr_n;
                    if (hdr_n == 16'd0 || 32'(hdr_n) > MAX_WORDS) begin
                        st_d   = L_ERROR;
                        ferr_d = 1'b1;
                    end else begin
                        st_d = L_DATA;
                    end
                end
            end
            L_DATA: begin
                // Completion is decided in the strobe cycle so cpu_reset drops one cycle later
                if (we_q && 16'(wc_q) == n_q) begin
                    st_d = L_DONE;
                end else if (rx_ferr_q) begin
                    st_d   = L_ERROR;
                    ferr_d = 1'b1;
                    bidx_d = '0;
                end else if (rx_valid_q) begin
                    word_d = {word_q[23:0], rx_byte_q};
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wc_q[ADDR_W-1:0];
                        wdata_d = {word_q[23:0], rx_byte_q};
                        wc_d    = (wc_q == 10'(MAX_WORDS)) ? wc_q : wc_q + 10'd1;
                    end
                end
            end
            default: begin
                if (start) begin
                    st_d   = L_HDR_HI;
                    ferr_d = 1'b0;
                    wc_d   = '0;
                    bidx_d = '0;
                end
            end
        endcase
        busy_d    = (st_d == L_HDR_HI) || (st_d == L_HDR_LO) || (st_d == L_DATA);
        done_d    = (st_d == L_DONE);
        cpu_rst_d = (st_d != L_DONE);
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_err  = ferr_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at 16 clocks per bit, with a reduced 32-word memory.
module tb_uart_prog_loader;
    localparam int unsigned CPB    = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned MAXW   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              uart_rx;
    logic              start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic [9:0]        word_count;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int nw = 0;
    int last_we_cyc = 0;
    int fall_cyc = -1;
    logic cpu_prev = 1'b1;
    logic [31:0] wr_addr [0:127];
    logic [31:0] wr_data [0:127];

    uart_prog_loader #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .ADDR_W   (ADDR_W),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .start     (start),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (nw < 128) begin
                wr_addr[nw] = 32'(imem_addr);
                wr_data[nw] = imem_wdata;
            end
            nw = nw + 1;
            last_we_cyc = cyc;
        end
        if (cpu_prev === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
        cpu_prev = cpu_reset;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, 8'hA5, ~b, 8'(i * 7)};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_wc"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        int base;
        reset   = 1'b1;
        uart_rx = 1'b1;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Test 1: two-word program
        base = nw;
        pulse_start();
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(32'h24080005);
        send_word(32'h0000000C);
        repeat (20) @(negedge clk);
        chk("t1_nw", 32'(nw - base), 32'd2);
        chk("t1_a0", wr_addr[base], 32'd0);
        chk("t1_d0", wr_data[base], 32'h24080005);
        chk("t1_a1", wr_addr[base+1], 32'd1);
        chk("t1_d1", wr_data[base+1], 32'h0000000C);
        chk("t1_wc", 32'(word_count), 32'd2);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpurst", 32'(cpu_reset), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_fall_lat", 32'(fall_cyc - last_we_cyc), 32'd1);

        // Test 2: zero-length header
        base = nw;
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        chk("t2_ferr", 32'(frame_err), 32'd1);
        chk("t2_nw", 32'(nw - base), 32'd0);
        chk("t2_cpurst", 32'(cpu_reset), 32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        pulse_start();
        chk("t2_ferr_clr", 32'(frame_err), 32'd0);
        chk("t2_busy_again", 32'(busy), 32'd1);

        // Test 3: oversize header, then a full-size load
        send_byte(8'h00, 1'b1);
        send_byte(8'h21, 1'b1);
        repeat (20) @(negedge clk);
        chk("t3_ferr_33", 32'(frame_err), 32'd1);
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        chk("t3_ferr_256", 32'(frame_err), 32'd1);
        base = nw;
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h20, 1'b1);
        chk("t3_accept", 32'(frame_err), 32'd0);
        for (int i = 0; i < 32; i++) send_word(pat(i));
        repeat (20) @(negedge clk);
        chk("t3_nw", 32'(nw - base), 32'd32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t3_a%0d", i), wr_addr[base+i], 32'(i));
            chk($sformatf("t3_d%0d", i), wr_data[base+i], pat(i));
        end
        chk("t3_wc", 32'(word_count), 32'd32);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_fall_lat", 32'(fall_cyc - last_we_cyc), 32'd1);

        // Test 4: bad stop bit on third data byte
        base = nw;
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (20) @(negedge clk);
        chk("t4_ferr", 32'(frame_err), 32'd1);
        chk("t4_cpurst", 32'(cpu_reset), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_wc", 32'(word_count), 32'd0);
        send_byte(8'h44, 1'b1);
        repeat (20) @(negedge clk);
        chk("t4_nw", 32'(nw - base), 32'd0);
        chk("t4_ferr_hold", 32'(frame_err), 32'd1);

        // Test 5: short low glitch while waiting for the header
        base = nw;
        pulse_start();
        @(negedge clk) uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_ferr", 32'(frame_err), 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(32'hDEADBEEF);
        repeat (20) @(negedge clk);
        chk("t5_nw", 32'(nw - base), 32'd1);
        chk("t5_a0", wr_addr[base], 32'd0);
        chk("t5_d0", wr_data[base], 32'hDEADBEEF);
        chk("t5_done", 32'(done), 32'd1);

        // Test 6: reset mid-word, then reload (with an ignored start while busy)
        base = nw;
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("t6_rst");
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("t6_nw_abort", 32'(nw - base), 32'd0);
        pulse_start();
        send_byte(8'h00, 1'b1);
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_word(32'hCAFEBABE);
        repeat (20) @(negedge clk);
        chk("t6_nw", 32'(nw - base), 32'd1);
        chk("t6_a0", wr_addr[base], 32'd0);
        chk("t6_d0", wr_data[base], 32'hCAFEBABE);
        chk("t6_wc", 32'(word_count), 32'd1);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_ferr", 32'(frame_err), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
